fifo_ctrl_sync: RTL and testbench

FIFO_CTRL_SYNC -- requirements
Module: fifo_ctrl_sync

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 37 +++
 rtl/fifo_ctrl_sync.sv | 146 ++++++++++++++
 tb/tb_fifo_ctrl_sync.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FSM state type and default sizing for the synchronous FIFO controller.
// Occupancy thresholds are in entries; depth must be a power of two.
package fifo_pkg;

  localparam int DEF_SIZE_DEPTH = 16;
  localparam int DEF_SIZE_ADDR  = 4;
  localparam int DEF_AF_TH      = 12;
  localparam int DEF_AE_TH      = 4;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping SIZE_ADDR+1 bit pointer: low bits address memory, MSB is the lap flag.
// Exposes next value so occupancy can be registered on the same edge as the pointer.
module fifo_ptr #(
  parameter int SIZE_ADDR = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_inc,
  output logic [SIZE_ADDR-1:0] o_addr,
  output logic [SIZE_ADDR:0]   o_ptr_nxt
);

  logic [SIZE_ADDR:0] ptr_q;
  logic [SIZE_ADDR:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_inc) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_addr    = ptr_q[SIZE_ADDR-1:0];
  assign o_ptr_nxt = ptr_d;

endmodule

// File: rtl/fifo_ctrl_sync.sv
// Single-clock FIFO controller driving an external 1-cycle-latency RAM; strobes are combinational, status registered.
// Full rejects pushes, empty rejects pops (no fall-through); FIFO_CTRL_ALMOST_EN adds almost-full/empty flags.
module fifo_ctrl_sync import fifo_pkg::*; #(
  parameter int SIZE_DEPTH = DEF_SIZE_DEPTH,
  parameter int SIZE_ADDR  = DEF_SIZE_ADDR,
  parameter int AF_TH      = DEF_AF_TH,
  parameter int AE_TH      = DEF_AE_TH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_req,
  input  logic                 i_rd_req,
  input  logic                 i_flush,
  output logic                 o_mem_wr_en,
  output logic [SIZE_ADDR-1:0] o_mem_addr_wr,
  output logic                 o_mem_rd_en,
  output logic [SIZE_ADDR-1:0] o_mem_addr_rd,
  output logic                 o_rd_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [SIZE_ADDR:0]   o_count,
  output logic                 o_overflow,
`ifdef FIFO_CTRL_ALMOST_EN
  output logic                 o_underflow,
  output logic                 o_almost_full,
  output logic                 o_almost_empty
`else
  output logic                 o_underflow
`endif
);

  localparam logic [SIZE_ADDR:0] DEPTH_M1 = (SIZE_ADDR+1)'(SIZE_DEPTH - 1);
  localparam logic [SIZE_ADDR:0] ONE      = (SIZE_ADDR+1)'(1);

  if (SIZE_DEPTH != (1 << SIZE_ADDR) || AF_TH > SIZE_DEPTH || AE_TH > SIZE_DEPTH) begin : g_param_chk
    $error("fifo_ctrl_sync: inconsistent SIZE_DEPTH/SIZE_ADDR/threshold parameters");
  end

  fifo_state_t        state_q, state_d;
  logic [SIZE_ADDR:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               udf_q, udf_d;
  logic               rd_valid_q, rd_valid_d;
  logic               wr_acc, rd_acc;
  logic [SIZE_ADDR:0] wr_nxt, rd_nxt;

  // Reset gating keeps the RAM strobes quiet while i_rst is high.
  assign wr_acc = i_wr_req && !o_full  && !i_flush && !i_rst;
  assign rd_acc = i_rd_req && !o_empty && !i_flush && !i_rst;

  fifo_ptr #(.SIZE_ADDR(SIZE_ADDR)) u_wr_ptr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_flush),
    .i_inc     (wr_acc),
    .o_addr    (o_mem_addr_wr),
    .o_ptr_nxt (wr_nxt)
  );

  fifo_ptr #(.SIZE_ADDR(SIZE_ADDR)) u_rd_ptr (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (i_flush),
    .i_inc     (rd_acc),
    .o_addr    (o_mem_addr_rd),
    .o_ptr_nxt (rd_nxt)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = wr_nxt - rd_nxt;
    ovf_d      = ovf_q | (i_wr_req && o_full);
    udf_d      = udf_q | (i_rd_req && o_empty);
    rd_valid_d = rd_acc;
    if (i_flush) begin
      state_d = ST_EMPTY;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY:  if (wr_acc) state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (wr_acc && !rd_acc && count_q == DEPTH_M1) begin
            state_d = ST_FULL;
          end else if (rd_acc && !wr_acc && count_q == ONE) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL:   if (rd_acc) state_d = ST_ACTIVE;
        default:   state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_EMPTY;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign o_mem_wr_en = wr_acc;
  assign o_mem_rd_en = rd_acc;
  assign o_rd_valid  = rd_valid_q;
  assign o_full      = (state_q == ST_FULL);
  assign o_empty     = (state_q == ST_EMPTY);
  assign o_count     = count_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = udf_q;

`ifdef FIFO_CTRL_ALMOST_EN
  localparam logic [SIZE_ADDR:0] AF_C = (SIZE_ADDR+1)'(AF_TH);
  localparam logic [SIZE_ADDR:0] AE_C = (SIZE_ADDR+1)'(AE_TH);

  logic af_q, af_d;
  logic ae_q, ae_d;

  always_comb begin
    af_d = (count_d >= AF_C);
    ae_d = (count_d <= AE_C);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      af_q <= (AF_TH == 0);
      ae_q <= 1'b1;
    end else begin
      af_q <= af_d;
      ae_q <= ae_d;
    end
  end

  assign o_almost_full  = af_q;
  assign o_almost_empty = ae_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Scoreboarded bench for fifo_ctrl_sync; a reference occupancy model predicts strobes, addresses and flags.
// Define FIFO_CTRL_ALMOST_EN to also check the almost-full/empty flags.
module tb_fifo_ctrl_sync;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_wr_req = 1'b0;
  logic          i_rd_req = 1'b0;
  logic          i_flush = 1'b0;
  logic          o_mem_wr_en, o_mem_rd_en, o_rd_valid;
  logic [AW-1:0] o_mem_addr_wr, o_mem_addr_rd;
  logic          o_full, o_empty, o_overflow, o_underflow;
  logic [AW:0]   o_count;
`ifdef FIFO_CTRL_ALMOST_EN
  logic          o_almost_full, o_almost_empty;
`endif

  fifo_ctrl_sync dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wr_req      (i_wr_req),
    .i_rd_req      (i_rd_req),
    .i_flush       (i_flush),
    .o_mem_wr_en   (o_mem_wr_en),
    .o_mem_addr_wr (o_mem_addr_wr),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_addr_rd (o_mem_addr_rd),
    .o_rd_valid    (o_rd_valid),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
`ifdef FIFO_CTRL_ALMOST_EN
    .o_underflow   (o_underflow),
    .o_almost_full (o_almost_full),
    .o_almost_empty(o_almost_empty)
`else
    .o_underflow   (o_underflow)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int   m_count, m_wp, m_rp;
  logic m_ovf, m_udf, m_rv;

  int wr_sb[$];
  int rd_sb[$];

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_wp = 0; m_rp = 0;
    m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0;
  endtask

  task automatic check_regs();
    chk_val("count", 32'(o_count), 32'(m_count));
    chk_val("full", 32'(o_full), 32'(m_count == DEPTH));
    chk_val("empty", 32'(o_empty), 32'(m_count == 0));
    chk_val("overflow", 32'(o_overflow), 32'(m_ovf));
    chk_val("underflow", 32'(o_underflow), 32'(m_udf));
    chk_val("rd_valid", 32'(o_rd_valid), 32'(m_rv));
`ifdef FIFO_CTRL_ALMOST_EN
    chk_val("almost_full", 32'(o_almost_full), 32'(m_count >= 12));
    chk_val("almost_empty", 32'(o_almost_empty), 32'(m_count <= 4));
`endif
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic wr, input logic rd, input logic fl);
    logic wacc, racc;
    check_regs();
    i_wr_req = wr; i_rd_req = rd; i_flush = fl;
    wacc = wr && (m_count != DEPTH) && !fl;
    racc = rd && (m_count != 0) && !fl;
    if (wacc) wr_sb.push_back(m_wp % DEPTH);
    if (racc) rd_sb.push_back(m_rp % DEPTH);
    #1;
    chk_val("wr_en", 32'(o_mem_wr_en), 32'(wacc));
    chk_val("rd_en", 32'(o_mem_rd_en), 32'(racc));
    if (o_mem_wr_en) begin
      if (wr_sb.size() == 0) chk_val("wr_sb_depth", 32'(wr_sb.size()), 32'd1);
      else chk_val("wr_addr", 32'(o_mem_addr_wr), 32'(wr_sb.pop_front()));
    end
    if (o_mem_rd_en) begin
      if (rd_sb.size() == 0) chk_val("rd_sb_depth", 32'(rd_sb.size()), 32'd1);
      else chk_val("rd_addr", 32'(o_mem_addr_rd), 32'(rd_sb.pop_front()));
    end
    @(posedge i_clk);
    if (fl) begin
      model_reset();
    end else begin
      m_ovf = m_ovf | (wr && m_count == DEPTH);
      m_udf = m_udf | (rd && m_count == 0);
      if (wacc) begin m_wp = (m_wp + 1) % (2*DEPTH); m_count++; end
      if (racc) begin m_rp = (m_rp + 1) % (2*DEPTH); m_count--; end
      m_rv = racc;
    end
    @(negedge i_clk);
  endtask

  initial begin
    model_reset();
    // Requests held high during reset must never strobe memory.
    i_wr_req = 1'b1; i_rd_req = 1'b1; i_flush = 1'b1;
    repeat (3) begin
      @(negedge i_clk); #1;
      chk_val("rst_wr_en", 32'(o_mem_wr_en), 32'd0);
      chk_val("rst_rd_en", 32'(o_mem_rd_en), 32'd0);
    end
    @(negedge i_clk);
    i_rst = 1'b0; i_wr_req = 1'b0; i_rd_req = 1'b0; i_flush = 1'b0;

    repeat (DEPTH) step(1'b1, 1'b0, 1'b0);       // fill, addresses 0..15
    step(1'b1, 1'b1, 1'b0);                      // full: pop wins, overflow set
    step(1'b0, 1'b0, 1'b1);                      // flush
    step(1'b0, 1'b1, 1'b0);                      // pop on empty
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b1, 1'b0);          // steady count 3, addresses wrap
    step(1'b0, 1'b0, 1'b1);
    repeat (7) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);                      // flush wins over push
    step(1'b1, 1'b0, 1'b0);                      // empty: push accepted
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);                      // empty push+pop: no fall-through
    step(1'b0, 1'b0, 1'b1);
    repeat (12) step(1'b1, 1'b0, 1'b0);          // almost-full boundary
    repeat (8) step(1'b0, 1'b1, 1'b0);           // almost-empty boundary
    step(1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic w, r, f;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      f = ($urandom_range(0, 63) == 0);
      step(w, r, f);
    end
    step(1'b0, 1'b0, 1'b0);
    chk_val("wr_sb_left", 32'(wr_sb.size()), 32'd0);
    chk_val("rd_sb_left", 32'(rd_sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
